// File: rtl/pool1_seq_ctrl_pkg.sv
// Shared definitions for the pool1 sequencer: default geometry, sequencer
// states and the pooled-output count helper.
package pool1_seq_ctrl_pkg;

    localparam int DW_DEF      = 32;
    localparam int CH_DEF      = 3;
    localparam int IN_W_DEF    = 26;
    localparam int IN_H_DEF    = 26;
    localparam int CLR_CYC_DEF = 2;

    // Number of 2x2 max-pool outputs produced for one w x h frame.
    function automatic int pool_outs(input int w, input int h);
        return (w / 2) * (h / 2);
    endfunction

    localparam int POOL_OUTS = pool_outs(IN_W_DEF, IN_H_DEF);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_FILL0  = 3'd2,
        ST_FILL1  = 3'd3,
        ST_ISSUE0 = 3'd4,
        ST_ISSUE1 = 3'd5,
        ST_DRAIN  = 3'd6,
        ST_DONE   = 3'd7
    } seq_state_t;

endpackage

// File: rtl/pool1_seq_ctrl_pair_buf.sv
// Two-entry pixel pair register. Slot 0 holds the even-x pixel, slot 1 the
// odd-x pixel; each slot carries a fill flag so the sequencer only accepts a
// pixel into an empty slot.
module pool1_pair_buf #(
    parameter int BW = 96
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          wr0,
    input  logic          wr1,
    input  logic [BW-1:0] din,
    output logic [BW-1:0] pair0,
    output logic [BW-1:0] pair1,
    output logic [1:0]    fill
);

    // Capture pixels into their slot; clr empties both slots once the pair is issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pair0 <= '0;
            pair1 <= '0;
            fill  <= 2'b00;
        end else begin
            if (clr) begin
                fill <= 2'b00;
            end
            if (wr0) begin
                pair0   <= din;
                fill[0] <= 1'b1;
            end
            if (wr1) begin
                pair1   <= din;
                fill[1] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pool1_seq_ctrl.sv
// Feeds one conv1 feature map into the free-running pool1 max-pool stage as
// gap-free x-pairs, captures pool1 results into a held output slot with
// downstream backpressure, and reports frame done / count error.
//
// Handshakes: a beat transfers on a rising clk edge where valid && ready are
// both high; valid never waits for ready, and m_valid/m_data stay stable
// until the beat transfers.
module pool1_seq_ctrl
    import pool1_seq_ctrl_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int CH      = CH_DEF,
    parameter int IN_W    = IN_W_DEF,
    parameter int IN_H    = IN_H_DEF,
    parameter int CLR_CYC = CLR_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DW*CH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [DW*CH-1:0] pool_data,
    output logic             pool_valid,
    output logic             pool_clr,
    input  logic [DW*CH-1:0] pool_res,
    input  logic             pool_res_valid,
    output logic [DW*CH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       state_dbg
);

    localparam int BW   = DW * CH;
    localparam int NPIX = IN_W * IN_H;
    localparam int NOUT = pool_outs(IN_W, IN_H);
    localparam int IW   = $clog2(NPIX + 1);
    localparam int OW   = $clog2(NOUT + 1);
    localparam int CW   = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

    localparam logic [IW-1:0] IN_TOTAL  = IW'(NPIX);
    localparam logic [OW-1:0] OUT_TOTAL = OW'(NOUT);
    localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_CYC - 1);

    seq_state_t      state;
    seq_state_t      state_next;
    logic [IW-1:0]   in_cnt;
    logic [OW-1:0]   out_cnt;
    logic [CW-1:0]   clr_cnt;
    logic [BW-1:0]   pair0;
    logic [BW-1:0]   pair1;
    logic [1:0]      fill;
    logic            wr0;
    logic            wr1;
    logic            pair_clr;
    logic            issue0_go;
    logic            issue1_go;
    logic            capture;

    assign state_dbg = state;
    assign capture   = pool_valid && pool_res_valid;
    assign pair_clr  = (state == ST_CLEAR) || issue1_go;

    pool1_pair_buf #(
        .BW (BW)
    ) u_pair_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pair_clr),
        .wr0   (wr0),
        .wr1   (wr1),
        .din   (s_data),
        .pair0 (pair0),
        .pair1 (pair1),
        .fill  (fill)
    );

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-state control strobes.
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        pool_clr   = 1'b0;
        wr0        = 1'b0;
        wr1        = 1'b0;
        issue0_go  = 1'b0;
        issue1_go  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                pool_clr = 1'b1;
                if (clr_cnt == CLR_LAST) begin
                    state_next = ST_FILL0;
                end
            end
            ST_FILL0: begin
                s_ready = !fill[0];
                if (s_valid && s_ready) begin
                    wr0        = 1'b1;
                    state_next = ST_FILL1;
                end
            end
            ST_FILL1: begin
                s_ready = !fill[1];
                if (s_valid && s_ready) begin
                    wr1        = 1'b1;
                    state_next = ST_ISSUE0;
                end
            end
            ST_ISSUE0: begin
                // Hold the pair back while an unaccepted result occupies the
                // output slot; once the pair starts it cannot be paused.
                if (!(m_valid && !m_ready)) begin
                    issue0_go  = 1'b1;
                    state_next = ST_ISSUE1;
                end
            end
            ST_ISSUE1: begin
                issue1_go = 1'b1;
                if ((in_cnt + IW'(2)) == IN_TOTAL) begin
                    state_next = ST_DRAIN;
                end else begin
                    state_next = ST_FILL0;
                end
            end
            ST_DRAIN: begin
                if (!pool_valid && (!m_valid || m_ready)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        // pool1 is kept cleared for as long as this block is held in reset.
        if (!rst_n) begin
            pool_clr = 1'b1;
        end
    end

    // Datapath: pool1 drive, result slot, frame counters and error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pool_data  <= '0;
            pool_valid <= 1'b0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            in_cnt     <= '0;
            out_cnt    <= '0;
            clr_cnt    <= '0;
            err        <= 1'b0;
        end else begin
            pool_valid <= 1'b0;
            if (issue0_go) begin
                pool_valid <= 1'b1;
                pool_data  <= pair0;
            end
            if (issue1_go) begin
                pool_valid <= 1'b1;
                pool_data  <= pair1;
                in_cnt     <= in_cnt + IW'(2);
            end

            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + CW'(1);
                in_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                clr_cnt <= '0;
                if (capture && (out_cnt != '1)) begin
                    out_cnt <= out_cnt + OW'(1);
                end
            end

            if (capture) begin
                m_data  <= pool_res;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            if ((state == ST_IDLE) && start) begin
                err <= 1'b0;
            end else if (state == ST_DONE) begin
                err <= (out_cnt != OUT_TOTAL);
            end
        end
    end

endmodule

// File: tb/tb_pool1_seq_ctrl.sv
// Bench for pool1_seq_ctrl: a streaming pool1 model answers the sequencer,
// and results are scored against 2x2 maxima computed directly from the frame.
module tb_pool1_seq_ctrl;

    localparam int DW   = 32;
    localparam int NCH  = 3;
    localparam int BW   = DW * NCH;
    localparam int W    = 26;
    localparam int H    = 26;
    localparam int NPIX = W * H;
    localparam int NOUT = (W / 2) * (H / 2);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start;
    logic [BW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [BW-1:0] pool_data;
    logic          pool_valid;
    logic          pool_clr;
    logic [BW-1:0] pool_res;
    logic          pool_res_valid;
    logic [BW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          busy;
    logic          done;
    logic          err;
    logic [2:0]    state_dbg;

    pool1_seq_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .pool_data      (pool_data),
        .pool_valid     (pool_valid),
        .pool_clr       (pool_clr),
        .pool_res       (pool_res),
        .pool_res_valid (pool_res_valid),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .state_dbg      (state_dbg)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] chmax(input logic [BW-1:0] a, input logic [BW-1:0] b);
        logic [BW-1:0] r;
        for (int k = 0; k < NCH; k++) begin
            r[k*DW +: DW] = (a[k*DW +: DW] > b[k*DW +: DW]) ? a[k*DW +: DW] : b[k*DW +: DW];
        end
        return r;
    endfunction

    // ---------------- pool1 behavioural model ----------------
    // Counts pixels since the last clear; its horizontal register samples
    // pool_data every cycle, so it relies on the two pixels of a pair being adjacent.
    int            pm_cnt = 0;
    int            pm_x;
    int            pm_y;
    logic [BW-1:0] pm_hold;
    logic [BW-1:0] pm_row [W/2];
    bit            kill_res = 1'b0;

    always @(posedge clk) begin
        pm_hold <= pool_data;
        if (pool_clr) begin
            pm_cnt <= 0;
        end else if (pool_valid) begin
            if ((pm_x % 2 == 1) && (pm_y % 2 == 0)) begin
                pm_row[pm_x / 2] <= chmax(pm_hold, pool_data);
            end
            pm_cnt <= pm_cnt + 1;
        end
    end

    always_comb begin
        pm_x           = pm_cnt % W;
        pm_y           = (pm_cnt / W) % H;
        pool_res       = chmax(chmax(pm_hold, pool_data), pm_row[pm_x / 2]);
        pool_res_valid = pool_valid && !pool_clr && !kill_res &&
                         (pm_x % 2 == 1) && (pm_y % 2 == 1);
    end

    // ---------------- frame data and expected queue ----------------
    logic [BW-1:0] img [NPIX];
    logic [BW-1:0] exp_q [$];

    task automatic gen_image();
        for (int i = 0; i < NPIX; i++) begin
            img[i] = {$urandom, $urandom, $urandom};
        end
    endtask

    task automatic build_expected();
        exp_q.delete();
        for (int oy = 0; oy < H / 2; oy++) begin
            for (int ox = 0; ox < W / 2; ox++) begin
                int p;
                p = (2 * oy) * W + 2 * ox;
                exp_q.push_back(chmax(chmax(img[p], img[p + 1]), chmax(img[p + W], img[p + W + 1])));
            end
        end
    endtask

    // ---------------- frame driver ----------------
    int res_cnt;
    int done_cnt;
    int pair_bad;
    int hold_bad;
    int sready_low_max;
    int clr_cycles;
    logic err_early;

    // gap_mode: 0 = s_valid always, 1 = 50% gaps.
    // rdy_mode: 0 = m_ready always, 1 = random, 2 = held low 40 cycles after first result.
    task automatic run_frame(input int gap_mode, input int rdy_mode, input int reset_at,
                             input int extra_start_at);
        int            src_idx = 0;
        int            run = 0;
        int            lowrun = 0;
        int            hold_left = 40;
        int            post_done = -1;
        bit            first_seen = 1'b0;
        bit            prev_stall = 1'b0;
        bit            extra_done = 1'b0;
        bit            finished = 1'b0;
        logic [BW-1:0] prev_mdata = '0;
        res_cnt = 0; done_cnt = 0; pair_bad = 0; hold_bad = 0;
        sready_low_max = 0; clr_cycles = 0; err_early = 1'b1;

        @(negedge clk);
        start = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
            start = 1'b0;
            if (extra_start_at >= 0 && !extra_done && src_idx >= extra_start_at) begin
                start      = 1'b1;
                extra_done = 1'b1;
            end
            s_valid = (src_idx < NPIX) && (gap_mode == 0 || $urandom_range(0, 1) == 1);
            if (src_idx < NPIX) s_data = img[src_idx];
            #1;
            if (m_valid) first_seen = 1'b1;
            case (rdy_mode)
                0: m_ready = 1'b1;
                1: m_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (first_seen && hold_left > 0) begin
                        m_ready = 1'b0;
                        hold_left--;
                    end else begin
                        m_ready = 1'b1;
                    end
                end
            endcase

            if (cyc == 1) err_early = err;
            if (busy && pool_clr) clr_cycles++;

            if (pool_valid) begin
                run++;
            end else begin
                if (run != 0 && run != 2) pair_bad++;
                run = 0;
            end

            if (prev_stall && (!m_valid || m_data !== prev_mdata)) hold_bad++;
            prev_stall = m_valid && !m_ready;
            prev_mdata = m_data;

            if (busy && !s_ready) lowrun++;
            else lowrun = 0;
            if (lowrun > sready_low_max) sready_low_max = lowrun;

            if (s_valid && s_ready) src_idx++;
            if (m_valid && m_ready) begin
                res_cnt++;
                if (exp_q.size() == 0) check("sb_extra_result", 1, 0);
                else check("sb_data", m_data, exp_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                if (post_done < 0) post_done = 0;
            end
            if (post_done >= 0) begin
                post_done++;
                if (post_done > 6) finished = 1'b1;
            end
            if (reset_at >= 0 && src_idx >= reset_at) finished = 1'b1;
            if (!finished) @(negedge clk);
        end
        if (!finished) check("frame_timeout", 0, 1);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_s_ready"},    s_ready,    0);
        check({pfx, "_pool_valid"}, pool_valid, 0);
        check({pfx, "_m_valid"},    m_valid,    0);
        check({pfx, "_busy"},       busy,       0);
        check({pfx, "_done"},       done,       0);
        check({pfx, "_err"},        err,        0);
        check({pfx, "_pool_clr"},   pool_clr,   1);
        check({pfx, "_pool_data"},  pool_data,  0);
        check({pfx, "_m_data"},     m_data,     0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("rst0");
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("idle_pool_clr", pool_clr, 0);
        check("idle_busy",     busy,     0);
        check("idle_s_ready",  s_ready,  0);

        // T1: continuous stream, always-ready sink
        gen_image();
        build_expected();
        run_frame(0, 0, -1, -1);
        check("t1_results",    res_cnt,       NOUT);
        check("t1_exp_left",   exp_q.size(),  0);
        check("t1_done_cnt",   done_cnt,      1);
        check("t1_err",        err,           0);
        check("t1_clr_cycles", clr_cycles,    2);
        check("t1_pairs",      pair_bad,      0);
        check("t1_busy_end",   busy,          0);

        // T2: 50% upstream gaps, same frame
        build_expected();
        run_frame(1, 0, -1, -1);
        check("t2_results",  res_cnt,  NOUT);
        check("t2_done_cnt", done_cnt, 1);
        check("t2_pairs",    pair_bad, 0);
        check("t2_err",      err,      0);

        // T3: sink stalls 40 cycles after the first result
        gen_image();
        build_expected();
        run_frame(0, 2, -1, -1);
        check("t3_results",      res_cnt,              NOUT);
        check("t3_hold_stable",  hold_bad,             0);
        check("t3_sready_stall", sready_low_max >= 30, 1);
        check("t3_pairs",        pair_bad,             0);
        check("t3_err",          err,                  0);

        // T4: reset at pixel 300, then a full frame with random sink readiness
        gen_image();
        build_expected();
        run_frame(0, 0, 300, -1);
        rst_n = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        #1;
        check_reset_values("t4_rst");
        rst_n = 1'b1;
        build_expected();
        run_frame(1, 1, -1, -1);
        check("t4_results",    res_cnt,    NOUT);
        check("t4_done_cnt",   done_cnt,   1);
        check("t4_clr_cycles", clr_cycles, 2);
        check("t4_pairs",      pair_bad,   0);
        check("t4_err",        err,        0);

        // T5: pool1 never reports a result
        exp_q.delete();
        kill_res = 1'b1;
        run_frame(0, 0, -1, -1);
        kill_res = 1'b0;
        check("t5_results",  res_cnt,  0);
        check("t5_done_cnt", done_cnt, 1);
        check("t5_err",      err,      1);
        repeat (20) @(negedge clk);
        #1;
        check("t5_err_sticky", err, 1);

        // T6: start pulsed mid-frame is ignored; err clears on the real start
        build_expected();
        run_frame(0, 1, -1, 100);
        check("t6_err_cleared", err_early, 0);
        check("t6_results",     res_cnt,   NOUT);
        check("t6_done_cnt",    done_cnt,  1);
        check("t6_err",         err,       0);
        check("t6_busy_end",    busy,      0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
